// File: rtl/ad5761_uart_cmd_pkg.sv
// Shared types and constants for the AD5761R UART command parser.
package ad5761_uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    DHI,
    DLO,
    CSUM,
    ISSUE,
    TX_REQ,
    TX_WAIT
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT  = 8'h5A;
  localparam logic [7:0] NAK_DEFAULT  = 8'hEE;

  function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
    return cmd ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/ad5761_uart_cmd_byte_timeout.sv
// Inter-byte watchdog: reload restarts the count, expire is high while enabled at zero.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 24000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (reload) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A reload in the expiry cycle means a byte arrived in time.
  assign expire = enable && !reload && (cnt == '0);

endmodule

// File: rtl/ad5761_uart_cmd.sv
// Parses {SYNC, CMD, DHI, DLO, CSUM} frames from the UART, issues a 24-bit AD5761R
// write word and answers each frame with ACK or NAK through the UART transmitter.
module ad5761_uart_cmd
  import ad5761_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 240_000_000,
  parameter int unsigned TIMEOUT_US = 100,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_DEFAULT,
  parameter logic [7:0]  ACK_BYTE   = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE   = NAK_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iR,
  input  logic [7:0]  iRDATA,
  output logic        oT_REQ,
  output logic [7:0]  oT_DATA,
  input  logic        iT_DONE,
  output logic        oCMD_VALID,
  output logic [23:0] oCMD_DATA,
  input  logic        iCMD_READY,
  output logic        oBUSY,
  output logic [7:0]  oERR_CNT,
  output logic [7:0]  oDROP_CNT
);

  localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;

  state_t      state, state_n;
  logic [7:0]  cmd_q, cmd_n;
  logic [7:0]  dhi_q, dhi_n;
  logic [7:0]  dlo_q, dlo_n;
  logic [1:0]  guard, guard_n;
  logic        t_req, t_req_n;
  logic [7:0]  t_data, t_data_n;
  logic        cmd_valid, cmd_valid_n;
  logic [23:0] cmd_data, cmd_data_n;
  logic [7:0]  err_cnt, err_cnt_n;
  logic [7:0]  drop_cnt, drop_cnt_n;
  logic        err_inc, drop_inc;
  logic        in_frame;
  logic        expire;

  assign in_frame = (state == CMD) || (state == DHI) || (state == DLO) || (state == CSUM);

  byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (iCLK),
    .rst   (iRST),
    .reload(iR),
    .enable(in_frame),
    .expire(expire)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= HUNT;
      cmd_q     <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      guard     <= '0;
      t_req     <= 1'b0;
      t_data    <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      cmd_q     <= cmd_n;
      dhi_q     <= dhi_n;
      dlo_q     <= dlo_n;
      guard     <= guard_n;
      t_req     <= t_req_n;
      t_data    <= t_data_n;
      cmd_valid <= cmd_valid_n;
      cmd_data  <= cmd_data_n;
      err_cnt   <= err_cnt_n;
      drop_cnt  <= drop_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cmd_n       = cmd_q;
    dhi_n       = dhi_q;
    dlo_n       = dlo_q;
    guard_n     = guard;
    t_req_n     = t_req;
    t_data_n    = t_data;
    cmd_valid_n = cmd_valid;
    cmd_data_n  = cmd_data;
    err_inc     = 1'b0;
    drop_inc    = 1'b0;

    unique case (state)
      HUNT: begin
        if (iR && (iRDATA == SYNC_BYTE)) state_n = CMD;
      end
      CMD: begin
        if (iR) begin
          cmd_n   = iRDATA;
          state_n = DHI;
        end else if (expire) begin
          err_inc = 1'b1;
          state_n = HUNT;
        end
      end
      DHI: begin
        if (iR) begin
          dhi_n   = iRDATA;
          state_n = DLO;
        end else if (expire) begin
          err_inc = 1'b1;
          state_n = HUNT;
        end
      end
      DLO: begin
        if (iR) begin
          dlo_n   = iRDATA;
          state_n = CSUM;
        end else if (expire) begin
          err_inc = 1'b1;
          state_n = HUNT;
        end
      end
      CSUM: begin
        if (iR) begin
          if ((iRDATA == frame_csum(cmd_q, dhi_q, dlo_q)) && (cmd_q[7:4] == 4'h0)) begin
            cmd_data_n  = {4'b0000, cmd_q[3:0], dhi_q, dlo_q};
            cmd_valid_n = 1'b1;
            state_n     = ISSUE;
          end else begin
            t_data_n = NAK_BYTE;
            err_inc  = 1'b1;
            guard_n  = 2'd0;
            state_n  = TX_REQ;
          end
        end else if (expire) begin
          err_inc = 1'b1;
          state_n = HUNT;
        end
      end
      ISSUE: begin
        drop_inc = iR;
        if (iCMD_READY) begin
          cmd_valid_n = 1'b0;
          t_data_n    = ACK_BYTE;
          guard_n     = 2'd0;
          state_n     = TX_REQ;
        end
      end
      TX_REQ: begin
        drop_inc = iR;
        // Keep the request low long enough for the UART's synchroniser to see an edge.
        if (guard == 2'd3) begin
          t_req_n = 1'b1;
          state_n = TX_WAIT;
        end else begin
          guard_n = guard + 2'd1;
        end
      end
      TX_WAIT: begin
        drop_inc = iR;
        if (iT_DONE) begin
          t_req_n = 1'b0;
          state_n = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase

    err_cnt_n  = (err_inc && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    drop_cnt_n = (drop_inc && (drop_cnt != 8'hFF)) ? drop_cnt + 8'd1 : drop_cnt;
  end

  assign oT_REQ     = t_req;
  assign oT_DATA    = t_data;
  assign oCMD_VALID = cmd_valid;
  assign oCMD_DATA  = cmd_data;
  assign oBUSY      = (state != HUNT);
  assign oERR_CNT   = err_cnt;
  assign oDROP_CNT  = drop_cnt;

endmodule

// File: tb/tb_ad5761_uart_cmd.sv
// Frame-level bench for ad5761_uart_cmd: table of frames plus hand-written corner sequences.
module tb_ad5761_uart_cmd;

  localparam int TO = 40;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iR;
  logic [7:0]  iRDATA;
  logic        oT_REQ;
  logic [7:0]  oT_DATA;
  logic        iT_DONE;
  logic        oCMD_VALID;
  logic [23:0] oCMD_DATA;
  logic        iCMD_READY;
  logic        oBUSY;
  logic [7:0]  oERR_CNT;
  logic [7:0]  oDROP_CNT;

  always #5 iCLK = ~iCLK;

  ad5761_uart_cmd #(
    .CLK_FREQ  (1_000_000),
    .TIMEOUT_US(TO)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iR        (iR),
    .iRDATA    (iRDATA),
    .oT_REQ    (oT_REQ),
    .oT_DATA   (oT_DATA),
    .iT_DONE   (iT_DONE),
    .oCMD_VALID(oCMD_VALID),
    .oCMD_DATA (oCMD_DATA),
    .iCMD_READY(iCMD_READY),
    .oBUSY     (oBUSY),
    .oERR_CNT  (oERR_CNT),
    .oDROP_CNT (oDROP_CNT)
  );

  typedef struct {
    logic [39:0] bytes;
    bit          has_cmd;
    logic [23:0] cmd;
    logic [7:0]  reply;
    bit          err_inc;
  } vec_t;

  vec_t vecs[7];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_rep_q[$];
  int   exp_err  = 0;
  int   exp_drop = 0;
  int   lowrun   = 0;
  int   last_gap = 0;
  int   rise_cnt = 0;
  logic prev_treq = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge iCLK); #1;
    iR = 1'b1; iRDATA = b;
    @(posedge iCLK); #1;
    iR = 1'b0; iRDATA = 8'h00;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int k = 4; k >= 0; k--) send_byte(f[k*8 +: 8]);
  endtask

  // Called once per negedge: scoreboards command handshakes and tracks request edges.
  task automatic mon_cycle();
    if (oCMD_VALID && iCMD_READY) begin
      if (exp_cmd_q.size() == 0) check("cmd_unexpected", 32'(oCMD_DATA), 32'hFFFF_FFFF);
      else check("cmd_data", 32'(oCMD_DATA), 32'(exp_cmd_q.pop_front()));
    end
    if (oT_REQ && !prev_treq) begin
      rise_cnt++;
      last_gap = lowrun;
      lowrun   = 0;
    end
    if (!oT_REQ) lowrun++;
    prev_treq = oT_REQ;
  endtask

  task automatic service(input int budget);
    int   r0;
    bit   got;
    logic [7:0] er;
    r0 = rise_cnt; got = 0; lowrun = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge iCLK);
      mon_cycle();
      if (rise_cnt != r0) got = 1;
    end
    check("reply_seen", 32'(got), 32'd1);
    if (got) begin
      if (exp_rep_q.size() == 0) check("reply_unexpected", 32'(oT_DATA), 32'h1FF);
      else begin
        er = exp_rep_q.pop_front();
        check("reply_byte", 32'(oT_DATA), 32'(er));
      end
      check("tx_gap_ge4", 32'(last_gap >= 4), 32'd1);
      repeat (3) begin @(negedge iCLK); mon_cycle(); end
      check("treq_hold", 32'(oT_REQ), 32'd1);
      iT_DONE = 1'b1;
      @(negedge iCLK);
      iT_DONE = 1'b0;
      mon_cycle();
      check("treq_fall", 32'(oT_REQ), 32'd0);
      check("busy_after_tx", 32'(oBUSY), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.has_cmd) exp_cmd_q.push_back(v.cmd);
    exp_rep_q.push_back(v.reply);
    if (v.err_inc) exp_err++;
    send_frame(v.bytes);
    check($sformatf("v%0d_valid_lat", idx), 32'(oCMD_VALID), 32'(v.has_cmd));
    service(40);
    check($sformatf("v%0d_err", idx), 32'(oERR_CNT), 32'(exp_err));
    check($sformatf("v%0d_drop", idx), 32'(oDROP_CNT), 32'(exp_drop));
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   r0;
    bit   stable;
    bit   got;

    vecs[0] = '{40'hA5_03_12_34_25, 1'b1, 24'h031234, 8'h5A, 1'b0};
    vecs[1] = '{40'hA5_03_12_34_00, 1'b0, 24'h000000, 8'hEE, 1'b1};
    vecs[2] = '{40'hA5_13_12_34_35, 1'b0, 24'h000000, 8'hEE, 1'b1};
    vecs[3] = '{40'hA5_0F_FF_00_F0, 1'b1, 24'h0FFF00, 8'h5A, 1'b0};
    vecs[4] = '{40'hA5_00_00_00_00, 1'b1, 24'h000000, 8'h5A, 1'b0};
    vecs[5] = '{40'hA5_0A_80_01_8B, 1'b1, 24'h0A8001, 8'h5A, 1'b0};
    vecs[6] = '{40'hA5_0A_80_01_8A, 1'b0, 24'h000000, 8'hEE, 1'b1};

    iRST = 1'b1; iR = 1'b0; iRDATA = 8'h00; iT_DONE = 1'b0; iCMD_READY = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_treq",  32'(oT_REQ), 32'd0);
    check("rst_tdata", 32'(oT_DATA), 32'd0);
    check("rst_valid", 32'(oCMD_VALID), 32'd0);
    check("rst_cdata", 32'(oCMD_DATA), 32'd0);
    check("rst_busy",  32'(oBUSY), 32'd0);
    check("rst_cnts",  32'({oERR_CNT, oDROP_CNT}), 32'd0);
    iRST = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Non-sync bytes in HUNT are ignored without counting.
    send_byte(8'h11);
    send_byte(8'h5A);
    #1;
    check("hunt_ignore_busy", 32'(oBUSY), 32'd0);
    check("hunt_ignore_cnts", 32'({oERR_CNT, oDROP_CNT}), 32'({exp_err[7:0], exp_drop[7:0]}));

    // Inter-byte timeout: still busy one cycle before expiry, back in HUNT right after.
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (TO) @(posedge iCLK);
    #1;
    check("to_busy_before", 32'(oBUSY), 32'd1);
    @(posedge iCLK); #1;
    exp_err++;
    check("to_busy_after", 32'(oBUSY), 32'd0);
    check("to_err", 32'(oERR_CNT), 32'(exp_err));
    r0 = rise_cnt;
    repeat (10) begin @(negedge iCLK); mon_cycle(); end
    check("to_no_reply", 32'(rise_cnt), 32'(r0));

    // Byte landing in the expiry cycle keeps the frame alive.
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (TO - 1) @(posedge iCLK);
    exp_cmd_q.push_back(24'h031234);
    exp_rep_q.push_back(8'h5A);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h25);
    check("exp_edge_valid", 32'(oCMD_VALID), 32'd1);
    service(40);
    check("exp_edge_err", 32'(oERR_CNT), 32'(exp_err));

    // SPI stage stalls 50 cycles while two bytes arrive and are dropped.
    iCMD_READY = 1'b0;
    exp_cmd_q.push_back(24'h031234);
    exp_rep_q.push_back(8'h5A);
    send_frame(40'hA5_03_12_34_25);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge iCLK); #1;
      iR = (i == 10 || i == 20); iRDATA = 8'hA5;
      @(negedge iCLK);
      if (!(oCMD_VALID === 1'b1 && oCMD_DATA === exp_cmd_q[0])) stable = 0;
    end
    @(posedge iCLK); #1;
    iR = 1'b0;
    exp_drop += 2;
    check("stall_stable", 32'(stable), 32'd1);
    check("stall_drop", 32'(oDROP_CNT), 32'(exp_drop));
    iCMD_READY = 1'b1;
    r0 = rise_cnt;
    service(40);
    repeat (20) begin @(negedge iCLK); mon_cycle(); end
    check("stall_one_ack", 32'(rise_cnt - r0), 32'd1);

    // Reset while waiting for the UART to finish.
    exp_cmd_q.push_back(24'h0A8001);
    send_frame(40'hA5_0A_80_01_8B);
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge iCLK);
      mon_cycle();
      if (oT_REQ) got = 1;
    end
    check("txwait_reached", 32'(got), 32'd1);
    check("txwait_ack", 32'(oT_DATA), 32'h5A);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    check("rst_tx_treq", 32'(oT_REQ), 32'd0);
    check("rst_tx_busy", 32'(oBUSY), 32'd0);
    check("rst_tx_rest", 32'({oT_DATA, oCMD_VALID, oCMD_DATA, oERR_CNT, oDROP_CNT} == '0), 32'd1);
    iRST = 1'b0;
    prev_treq = 1'b0;
    exp_err = 0;
    exp_drop = 0;
    run_vec(vecs[0], 100);

    check("cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("rep_q_empty", 32'(exp_rep_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
